// File: rtl/queue_manager_mt.sv
// queue_manager_mt: multi-teller bank queue manager.
// Counts customers from two active-low photocell sensors, tracks the open
// teller count and derives an estimated wait (ceil(Pcount/tcount)*SVC_TIME,
// saturated) with a one-subtract-per-cycle divider.
// Optional build macro: QUEUE_MANAGER_MT_DEBOUNCE_EN adds per-sensor debounce
// (DB_CYCLES consecutive stable samples to fire / re-arm).

// Per-sensor front end: 2-FF synchroniser plus falling-edge event.
module qm_sensor #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rest,
  input  logic sens_i,
  output logic evt_o
);
  logic s1_q, s2_q;

  // Synchroniser, idles high so reset never produces a spurious event
  always_ff @(posedge clk) begin
    if (rest) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= sens_i;
      s2_q <= s1_q;
    end
  end

`ifdef QUEUE_MANAGER_MT_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] lo_q, lo_d, hi_q, hi_d;
  logic          armed_q, armed_d;

  // Debounce: lo/hi count earlier consecutive low/high samples (saturating)
  always_comb begin
    lo_d    = lo_q;
    hi_d    = hi_q;
    armed_d = armed_q;
    evt_o   = 1'b0;
    if (!s2_q) begin
      hi_d = '0;
      lo_d = (lo_q == LAST) ? lo_q : lo_q + 1'b1;
      if (armed_q && lo_q == LAST) begin
        evt_o   = 1'b1;
        armed_d = 1'b0;
      end
    end else begin
      lo_d = '0;
      hi_d = (hi_q == LAST) ? hi_q : hi_q + 1'b1;
      if (!armed_q && hi_q == LAST) armed_d = 1'b1;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (rest) begin
      lo_q    <= '0;
      hi_q    <= '0;
      armed_q <= 1'b1;
    end else begin
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      armed_q <= armed_d;
    end
  end
`else
  logic prev_q;

  // Previous synchronised value for edge detection
  always_ff @(posedge clk) begin
    if (rest) prev_q <= 1'b1;
    else      prev_q <= s2_q;
  end

  assign evt_o = prev_q & ~s2_q;
`endif
endmodule

module queue_manager_mt #(
  parameter int N         = 3,
  parameter int T_W       = 2,
  parameter int SVC_TIME  = 3,
  parameter int WT_W      = 5,
  parameter int DB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rest,
  input  logic            backphoto,
  input  logic            forwardphoto,
  input  logic [T_W-1:0]  tcount,
  output logic [N-1:0]    Pcount,
  output logic [WT_W-1:0] Wtime,
  output logic            wt_valid,
  output logic            full,
  output logic            empty
);
  localparam logic [N-1:0]    PMAX = {N{1'b1}};
  localparam logic [WT_W-1:0] WMAX = {WT_W{1'b1}};
  // Product width before saturation
  localparam int MW = N + $clog2(SVC_TIME) + 1;
  localparam int XW = (MW > WT_W) ? MW : WT_W;
  localparam int SW = (N > T_W) ? N : T_W;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} st_e;

  logic [1:0]      evt;
  logic            ent, ext;
  logic [N-1:0]    pcnt_q, pcnt_d;
  logic [T_W-1:0]  tc_q;
  logic            trig;
  st_e             st_q, st_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [WT_W-1:0] wt_q, wt_d;
  logic            vld_q, vld_d;
  logic [MW-1:0]   prod;
  logic [XW-1:0]   prod_x;

  // Entry (lane 0) and exit (lane 1) sensors share one front end
  qm_sensor #(.DB_CYCLES(DB_CYCLES)) u_sens [1:0] (
    .clk   (clk),
    .rest  (rest),
    .sens_i({forwardphoto, backphoto}),
    .evt_o (evt)
  );

  assign ent = evt[0];
  assign ext = evt[1];

  assign full   = (pcnt_q == PMAX);
  assign empty  = (pcnt_q == '0);
  assign Pcount = pcnt_q;
  assign Wtime  = wt_q;
  assign wt_valid = vld_q;

  // Customer count: saturating in both directions; a simultaneous exit at
  // zero is treated as bogus so only the entry counts
  always_comb begin
    pcnt_d = pcnt_q;
    unique case ({ent, ext})
      2'b10:   if (!full)  pcnt_d = pcnt_q + 1'b1;
      2'b01:   if (!empty) pcnt_d = pcnt_q - 1'b1;
      2'b11:   if (empty)  pcnt_d = pcnt_q + 1'b1;
      default: ;
    endcase
  end

  // Recompute whenever the count or the registered teller count moves
  assign trig = (pcnt_d != pcnt_q) || (tcount != tc_q);

  assign prod   = MW'(quo_q) * MW'(SVC_TIME);
  assign prod_x = XW'(prod);

  // Divider FSM: next state and datapath; a trigger restarts from any state
  always_comb begin
    st_d  = st_q;
    rem_d = rem_q;
    quo_d = quo_q;
    wt_d  = wt_q;
    vld_d = vld_q;
    if (trig) begin
      rem_d = pcnt_d;
      quo_d = '0;
      vld_d = 1'b0;
      // No tellers: nothing to divide, go straight to the result
      st_d  = (tcount == '0) ? S_DONE : S_DIV;
    end else begin
      unique case (st_q)
        S_DIV: begin
          if (rem_q == '0) begin
            st_d = S_DONE;
          end else begin
            if (SW'(rem_q) <= SW'(tc_q)) rem_d = '0;
            else                         rem_d = N'(SW'(rem_q) - SW'(tc_q));
            quo_d = quo_q + 1'b1;
          end
        end
        S_DONE: begin
          if (tc_q == '0)              wt_d = (rem_q == '0) ? '0 : WMAX;
          else if (prod_x > XW'(WMAX)) wt_d = WMAX;
          else                         wt_d = prod_x[WT_W-1:0];
          vld_d = 1'b1;
          st_d  = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // State, count and result registers
  always_ff @(posedge clk) begin
    if (rest) begin
      pcnt_q <= '0;
      tc_q   <= '0;
      st_q   <= S_IDLE;
      rem_q  <= '0;
      quo_q  <= '0;
      wt_q   <= '0;
      vld_q  <= 1'b1;
    end else begin
      pcnt_q <= pcnt_d;
      tc_q   <= tcount;
      st_q   <= st_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      wt_q   <= wt_d;
      vld_q  <= vld_d;
    end
  end
endmodule

// File: tb/tb_queue_manager_mt.sv
// Directed bench for queue_manager_mt (N=3, T_W=2, SVC_TIME=3, WT_W=5).
module tb_queue_manager_mt;
`ifdef QUEUE_MANAGER_MT_DEBOUNCE_EN
  localparam int LAT = 4 + 2;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rest = 1'b1;
  logic       backphoto = 1'b1;
  logic       forwardphoto = 1'b1;
  logic [1:0] tcount = 2'd2;
  logic [2:0] Pcount;
  logic [4:0] Wtime;
  logic       wt_valid, full, empty;

  int vecs = 0;
  int errs = 0;

  queue_manager_mt #(.N(3), .T_W(2), .SVC_TIME(3), .WT_W(5), .DB_CYCLES(4)) dut (
    .clk(clk), .rest(rest), .backphoto(backphoto), .forwardphoto(forwardphoto),
    .tcount(tcount), .Pcount(Pcount), .Wtime(Wtime), .wt_valid(wt_valid),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rest = 1'b1; backphoto = 1'b1; forwardphoto = 1'b1;
    tick(2);
    rest = 1'b0;
    tick(6);
  endtask

  // Hold the selected sensors low long enough for either build, then idle
  task automatic pulse(input logic b, input logic f);
    @(negedge clk);
    backphoto = ~b; forwardphoto = ~f;
    tick(8);
    backphoto = 1'b1; forwardphoto = 1'b1;
    tick(8);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rest = 1'b1; tcount = 2'd2;
    tick(2);
    vecs++;
    if (Pcount !== 3'd0 || Wtime !== 5'd0 || wt_valid !== 1'b1 || empty !== 1'b1 || full !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: P=%0d W=%0d v=%b e=%b f=%b, want 0 0 1 1 0", Pcount, Wtime, wt_valid, empty, full);
    end
    rest = 1'b0;
    tick(6);
  endtask

  task automatic test_enter();
    do_reset();
    // Latency check on the first entry
    backphoto = 1'b0;
    tick(LAT - 1);
    vecs++;
    if (Pcount !== 3'd0) begin errs++; $display("FAIL enter_early: Pcount=%0d want 0", Pcount); end
    tick(1);
    vecs++;
    if (Pcount !== 3'd1 || wt_valid !== 1'b0) begin
      errs++; $display("FAIL enter_latency: Pcount=%0d v=%b want 1 0", Pcount, wt_valid);
    end
    tick(7);
    backphoto = 1'b1;
    tick(8);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    vecs++;
    if (Pcount !== 3'd3 || empty !== 1'b0 || Wtime !== 5'd6 || wt_valid !== 1'b1) begin
      errs++; $display("FAIL enter3: P=%0d e=%b W=%0d v=%b want 3 0 6 1", Pcount, empty, Wtime, wt_valid);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0);
    vecs++;
    if (Pcount !== 3'd7 || full !== 1'b1) begin errs++; $display("FAIL fill7: P=%0d full=%b want 7 1", Pcount, full); end
    pulse(1'b1, 1'b0);
    vecs++;
    if (Pcount !== 3'd7 || full !== 1'b1 || Wtime !== 5'd12 || wt_valid !== 1'b1) begin
      errs++; $display("FAIL sat8: P=%0d f=%b W=%0d v=%b want 7 1 12 1", Pcount, full, Wtime, wt_valid);
    end
    pulse(1'b0, 1'b1);
    vecs++;
    if (Pcount !== 3'd6 || full !== 1'b0 || Wtime !== 5'd9) begin
      errs++; $display("FAIL exit_dec: P=%0d f=%b W=%0d want 6 0 9", Pcount, full, Wtime);
    end
  endtask

  task automatic test_empty_exit();
    do_reset();
    pulse(1'b0, 1'b1);
    vecs++;
    if (Pcount !== 3'd0 || empty !== 1'b1 || wt_valid !== 1'b1 || Wtime !== 5'd0) begin
      errs++; $display("FAIL empty_exit: P=%0d e=%b v=%b W=%0d want 0 1 1 0", Pcount, empty, wt_valid, Wtime);
    end
  endtask

  task automatic test_both();
    do_reset();
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    vecs++;
    if (Pcount !== 3'd4 || Wtime !== 5'd6) begin
      errs++; $display("FAIL both_at4: P=%0d W=%0d want 4 6", Pcount, Wtime);
    end
    do_reset();
    pulse(1'b1, 1'b1);
    vecs++;
    if (Pcount !== 3'd1 || empty !== 1'b0 || Wtime !== 5'd3) begin
      errs++; $display("FAIL both_at0: P=%0d e=%b W=%0d want 1 0 3", Pcount, empty, Wtime);
    end
  endtask

  task automatic test_tellers();
    do_reset();
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    vecs++;
    if (Pcount !== 3'd5 || Wtime !== 5'd9) begin errs++; $display("FAIL five_t2: P=%0d W=%0d want 5 9", Pcount, Wtime); end
    tcount = 2'd0;
    tick(4);
    vecs++;
    if (Wtime !== 5'd31 || wt_valid !== 1'b1) begin
      errs++; $display("FAIL t0_sat: W=%0d v=%b want 31 1", Wtime, wt_valid);
    end
    tcount = 2'd1;
    tick(3);
    vecs++;
    if (wt_valid !== 1'b0 || Wtime !== 5'd31) begin
      errs++; $display("FAIL div_busy: v=%b W=%0d want 0 31", wt_valid, Wtime);
    end
    tcount = 2'd3;
    tick(2);
    vecs++;
    if (wt_valid !== 1'b0) begin errs++; $display("FAIL restart_hold: v=%b want 0", wt_valid); end
    tick(10);
    vecs++;
    if (Wtime !== 5'd6 || wt_valid !== 1'b1) begin
      errs++; $display("FAIL restart_t3: W=%0d v=%b want 6 1", Wtime, wt_valid);
    end
    tcount = 2'd2;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0);
    tcount = 2'd1;
    tick(3);
    vecs++;
    if (wt_valid !== 1'b0) begin errs++; $display("FAIL mid_div: v=%b want 0", wt_valid); end
    rest = 1'b1;
    tick(1);
    vecs++;
    if (Pcount !== 3'd0 || Wtime !== 5'd0 || wt_valid !== 1'b1 || empty !== 1'b1) begin
      errs++; $display("FAIL abort: P=%0d W=%0d v=%b e=%b want 0 0 1 1", Pcount, Wtime, wt_valid, empty);
    end
    rest = 1'b0;
    tcount = 2'd2;
    tick(6);
  endtask

  task automatic test_glitch();
    do_reset();
    backphoto = 1'b0;
    tick(2);
    backphoto = 1'b1;
    tick(12);
    vecs++;
`ifdef QUEUE_MANAGER_MT_DEBOUNCE_EN
    if (Pcount !== 3'd0) begin errs++; $display("FAIL glitch_db: P=%0d want 0", Pcount); end
`else
    if (Pcount !== 3'd1) begin errs++; $display("FAIL glitch_nodb: P=%0d want 1", Pcount); end
`endif
  endtask

  initial begin
    test_reset();
    test_enter();
    test_full();
    test_empty_exit();
    test_both();
    test_tellers();
    test_reset_mid();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
